imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. It takes a byte stream from a host link (e.g. a UART receiver) through a valid/ready handshake and checks a length/checksum frame. It assembles little-endian 32-bit words and drives the instruction memory write port at consecutive word addresses. While a load is in progress it holds the core in reset, then reports completion and status.

## Interface
- DEPTH, 32: number of instruction words in the memory; the maximum frame length.
- ADDR_W, 5: word-address width; DEPTH ≤ 2^ADDR_W.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that arms a load; ignored unless the block is in IDLE.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  block accepts a byte this cycle.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  holds the core in reset while a load is active.
- done  out  1  single-cycle pulse at the end of a frame, both pass and fail.
- error  out  1  status of the last frame; sticky until the next accepted start.

## Operation
- Frame format: one length byte N, then 4·N data bytes (each word LSB first), then one checksum byte C.
- Checksum rule: the 8-bit sum (mod 256) of N, all data bytes and C must equal 0.
- A byte is accepted only on a cycle where byte_valid and byte_ready are both high. byte_data is ignored on any other cycle.
- IDLE
  - byte_ready=0, cpu_hold=0.
  - On start: clear error, clear the running sum and the word index, set cpu_hold=1, go to LEN.
- LEN
  - byte_ready=1.
  - On acceptance, N is added to the sum.
  - If N=0 or N>DEPTH: go to FIN with a length error.
  - Otherwise latch N and go to DATA.
- DATA
  - byte_ready=1.
  - Each accepted byte is shifted into a 32-bit assembly register at byte lane k (k=0..3) and added to the sum.
  - On acceptance of lane 3, a write of the assembled word is scheduled and the word index increments.
  - After word N-1 is accepted, go to CSUM.
- CSUM
  - byte_ready=1.
  - On acceptance, C is added to the sum; go to FIN.
  - A nonzero final sum sets the checksum error.
- FIN
  - For one cycle: done=1, error=1 if a length or checksum error occurred, cpu_hold stays 1.
  - Next cycle: return to IDLE, cpu_hold=0.
- No data words are written on a length error.
- On a checksum error, words already written stay in memory. The error flag tells the host to reload.
- start is ignored while the state is not IDLE, including a start that coincides with the transition from FIN to IDLE.
- Asynchronous reset, including mid-frame:
  - State goes to IDLE; the sum, the word index and the assembly register clear.
  - Partially written memory contents are left as they are.
  - Before the next start, the host restarts the frame from the length byte.

## Timing
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0.
- All outputs are registered except byte_ready, which is decoded from the state.
- Latency from start to the next cycle:
  - The state is LEN.
  - cpu_hold=1 and byte_ready=1.
- Throughput: one byte per cycle at most; with byte_valid held high, byte_ready is never deasserted mid-frame.
- Write timing:
  - mem_we=1 for exactly one cycle, on the cycle after lane 3 of word i is accepted.
  - On that cycle mem_addr=i and mem_wdata={b3,b2,b1,b0}.
- Acceptance continues during a write cycle with no bubble.
- The final word's mem_we occurs on the same cycle that the block is in CSUM.
- done pulses on the cycle after C is accepted, or on the cycle after a bad N is accepted.
- error is valid on the done cycle and holds until the next accepted start.
- With a fully streaming host, total cycles from start to done = 1 + (1 + 4N + 1).

## Test plan
- Good frame
  - Stimulus after start: stream 02, 93 80 10 00, 13 01 11 00, B6.
  - Required: mem_we pulses at addr 0 with 0x00108093 and at addr 1 with 0x00110113; done=1 with error=0; cpu_hold high from the cycle after start through the done cycle.
- Bad checksum
  - Stimulus: same frame with the last byte B7.
  - Required: both words are written, done=1 with error=1, cpu_hold=0 after done.
- Length error
  - Stimulus: length byte 00, then a separate frame with length byte 21 (33 > DEPTH).
  - Required: each frame gets done with error=1 immediately after the length byte and no mem_we.
- Throttled host
  - Stimulus: good frame with byte_valid toggling randomly; byte_data held at garbage 0xFF while byte_valid=0.
  - Required: identical writes and checksum result to the good frame.
- Reset mid-frame and ignored start
  - Stimulus: assert reset after the 5th data byte; then send a full good frame of length 1 (01, 93 80 10 00, 5C).
  - Required: outputs return to reset values on reset; the new frame writes only addr 0 with 0x00108093, done with error=0.
  - Required: a start pulse sent during DATA is ignored.
- Full-depth frame
  - Stimulus: N=32 with mem_wdata pattern 0x1000_0000+i and the matching checksum.
  - Required: 32 writes at addr 0..31 in order, done with error=0, the word index does not wrap.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: accepts a length/data/checksum byte frame and writes little-endian
// 32-bit words into the instruction memory while holding the core in reset.
module imem_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StFin} state_t;

    localparam logic [7:0] DepthByte = 8'(DEPTH);

    state_t            state_q, state_d;
    logic [7:0]        sum_q, sum_d;
    // One bit wider than the address so a full-depth count never wraps.
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       asm_q, asm_d;
    logic              error_q, error_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;

    logic              accept;
    logic [7:0]        sum_acc;
    logic [ADDR_W:0]   idx_inc;

    assign byte_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign accept     = byte_valid && byte_ready;
    assign sum_acc    = sum_q + byte_data;
    assign idx_inc    = idx_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        len_d       = len_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        asm_d       = asm_q;
        error_d     = error_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    error_d = 1'b0;
                    sum_d   = 8'h00;
                    idx_d   = '0;
                    lane_d  = 2'd0;
                    asm_d   = 32'h0;
                    state_d = StLen;
                end
            end
            StLen: begin
                if (accept) begin
                    sum_d = sum_acc;
                    if (byte_data == 8'h00 || byte_data > DepthByte) begin
                        error_d = 1'b1;
                        state_d = StFin;
                    end else begin
                        len_d   = (ADDR_W+1)'(byte_data);
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    sum_d                     = sum_acc;
                    asm_d[{lane_q, 3'b000} +: 8] = byte_data;
                    lane_d                    = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = idx_q[ADDR_W-1:0];
                        mem_wdata_d = {byte_data, asm_q[23:0]};
                        idx_d       = idx_inc;
                        if (idx_inc == len_q) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    sum_d   = sum_acc;
                    state_d = StFin;
                    if (sum_acc != 8'h00) begin
                        error_d = 1'b1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cpu_hold_d = (state_d != StIdle);
        done_d     = (state_d == StFin);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sum_q       <= 8'h00;
            len_q       <= '0;
            idx_q       <= '0;
            lane_q      <= 2'd0;
            asm_q       <= 32'h0;
            error_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            asm_q       <= asm_d;
            error_q     <= error_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good, bad-checksum, bad-length, throttled,
// reset mid-frame and full-depth frames.
module tb_imem_loader;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned done_cnt = 0;
    int unsigned cyc_start;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [31:0]       exp_q[$];
    logic [7:0]        frame[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start     = 1'b1;
        cyc_start = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit throttle);
        bit ok;
        if (throttle) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                byte_data  = 8'hFF;
                step();
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = byte_ready;
            step();
        end
        byte_valid = 1'b0;
        byte_data  = 8'hFF;
        if (!ok) check_eq("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input bit throttle);
        foreach (frame[i]) send_byte(frame[i], throttle);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_nwrites"}, wr_data_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
            check_eq({tag, "_addr"}, 32'(wr_addr_q[i]), i);
            check_eq({tag, "_data"}, wr_data_q[i], exp_q[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(byte_ready), 0);
        check_eq({tag, "_we"}, 32'(mem_we), 0);
        check_eq({tag, "_addr"}, 32'(mem_addr), 0);
        check_eq({tag, "_wdata"}, mem_wdata, 0);
        check_eq({tag, "_hold"}, 32'(cpu_hold), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_error"}, 32'(error), 0);
    endtask

    task automatic load_good_frame();
        frame = '{8'h02, 8'h93, 8'h80, 8'h10, 8'h00, 8'h13, 8'h01, 8'h11, 8'h00, 8'hB6};
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'hFF;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Good frame
        clear_log();
        load_good_frame();
        pulse_start();
        check_eq("good_hold_after_start", 32'(cpu_hold), 1);
        check_eq("good_ready_after_start", 32'(byte_ready), 1);
        send_frame(1'b0);
        check_eq("good_done", 32'(done), 1);
        check_eq("good_error", 32'(error), 0);
        check_eq("good_hold_on_done", 32'(cpu_hold), 1);
        check_eq("good_cycles", cyc - cyc_start, 11);
        step();
        check_eq("good_done_pulse", 32'(done), 0);
        check_eq("good_hold_after_done", 32'(cpu_hold), 0);
        exp_q = '{32'h00108093, 32'h00110113};
        check_writes("good");
        check_eq("good_done_count", done_cnt, 1);

        // Bad checksum, with a start during FIN that must be ignored
        clear_log();
        load_good_frame();
        frame[frame.size()-1] = 8'hB7;
        pulse_start();
        send_frame(1'b0);
        check_eq("badcs_done", 32'(done), 1);
        check_eq("badcs_error", 32'(error), 1);
        pulse_start();
        check_eq("badcs_hold_after_done", 32'(cpu_hold), 0);
        check_eq("badcs_fin_start_ignored", 32'(byte_ready), 0);
        step();
        check_eq("badcs_error_sticky", 32'(error), 1);
        exp_q = '{32'h00108093, 32'h00110113};
        check_writes("badcs");

        // Length errors: N=0 and N=33
        clear_log();
        pulse_start();
        check_eq("len0_error_cleared", 32'(error), 0);
        send_byte(8'h00, 1'b0);
        check_eq("len0_done", 32'(done), 1);
        check_eq("len0_error", 32'(error), 1);
        step();
        pulse_start();
        send_byte(8'h21, 1'b0);
        check_eq("len33_done", 32'(done), 1);
        check_eq("len33_error", 32'(error), 1);
        step();
        step();
        check_writes("lenerr");
        check_eq("lenerr_done_count", done_cnt, 2);

        // Throttled host
        clear_log();
        load_good_frame();
        pulse_start();
        send_frame(1'b1);
        check_eq("thr_done", 32'(done), 1);
        check_eq("thr_error", 32'(error), 0);
        step();
        exp_q = '{32'h00108093, 32'h00110113};
        check_writes("thr");

        // Start during DATA is ignored; reset after the 5th data byte
        clear_log();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h10, 1'b0);
        start = 1'b1;
        send_byte(8'h00, 1'b0);
        start = 1'b0;
        send_byte(8'h13, 1'b0);
        exp_q = '{32'h00108093};
        check_writes("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        step();
        reset = 1'b0;
        step();
        clear_log();
        // 01+93+80+10+00 = 0x24, so the balancing checksum is 0xDC
        frame = '{8'h01, 8'h93, 8'h80, 8'h10, 8'h00, 8'hDC};
        pulse_start();
        send_frame(1'b0);
        check_eq("n1_done", 32'(done), 1);
        check_eq("n1_error", 32'(error), 0);
        step();
        exp_q = '{32'h00108093};
        check_writes("n1");

        // Full-depth frame: sum = 0x20 + 496 + 32*0x10 = 0x410 -> checksum 0xF0
        clear_log();
        frame.delete();
        frame.push_back(8'h20);
        for (int i = 0; i < 32; i++) begin
            frame.push_back(8'(i));
            frame.push_back(8'h00);
            frame.push_back(8'h00);
            frame.push_back(8'h10);
            exp_q.push_back(32'h1000_0000 + i);
        end
        frame.push_back(8'hF0);
        pulse_start();
        send_frame(1'b0);
        check_eq("full_done", 32'(done), 1);
        check_eq("full_error", 32'(error), 0);
        check_eq("full_cycles", cyc - cyc_start, 131);
        step();
        check_writes("full");
        check_eq("full_done_count", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
